// File: rtl/work_dispatcher_if.sv
// Core-facing bundle of the work dispatcher: push, entry-PC request/return, table writes, FIFO status.
// The drop_cnt signal exists only when DISPATCH_DROP_CNT_EN is defined.
interface work_dispatcher_if;
    logic        queue_wen;
    logic [3:0]  queue_number;
    logic        request_new_pc;
    logic [15:0] new_pc;
    logic [1:0]  idle;
    logic        halt;
    logic        tbl_wen;
    logic [3:0]  tbl_waddr;
    logic [15:0] tbl_wdata;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
`ifdef DISPATCH_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    modport master (
        output queue_wen, queue_number, request_new_pc, halt, tbl_wen, tbl_waddr, tbl_wdata,
        input  new_pc, idle, fifo_count, fifo_full, fifo_empty
`ifdef DISPATCH_DROP_CNT_EN
        , input drop_cnt
`endif
    );

    modport slave (
        input  queue_wen, queue_number, request_new_pc, halt, tbl_wen, tbl_waddr, tbl_wdata,
        output new_pc, idle, fifo_count, fifo_full, fifo_empty
`ifdef DISPATCH_DROP_CNT_EN
        , output drop_cnt
`endif
    );
endinterface

// File: rtl/work_dispatcher.sv
// Work dispatcher: 8-deep queue-id FIFO feeding a 16-entry PC table lookup for one core.
// Optional DISPATCH_DROP_CNT_EN adds a saturating count of pushes dropped while full.
module work_dispatcher (
    input  logic           clk,
    input  logic           rst_n,
    work_dispatcher_if.slave bus
);
    // idle is the state register itself, so it doubles as the FSM debug view.
    typedef enum logic [1:0] {
        ST_SERVE = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] new_pc_q, new_pc_d;
    logic [3:0]  fifo_q [8];
    logic [2:0]  rd_ptr_q, wr_ptr_q;
    logic [3:0]  count_q;
    logic [15:0] table_q [16];

    logic        empty, full, pop, push_ok, drop;
    logic [3:0]  head_id;

    assign empty   = (count_q == 4'd0);
    assign full    = (count_q == 4'd8);
    assign head_id = fifo_q[rd_ptr_q];
    // A pop frees the slot the push needs, so a full FIFO still accepts then.
    assign push_ok = bus.queue_wen && (!full || pop);
    assign drop    = bus.queue_wen && full && !pop;

    always_comb begin
        state_d  = state_q;
        new_pc_d = new_pc_q;
        pop      = 1'b0;
        case (state_q)
            ST_SERVE: begin
                if (bus.request_new_pc) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        new_pc_d = table_q[head_id];
                    end else if (bus.halt) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!empty) begin
                    pop      = 1'b1;
                    new_pc_d = table_q[head_id];
                    state_d  = ST_SERVE;
                end else if (bus.halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!bus.halt) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_WAIT;
            new_pc_q <= 16'h0000;
            rd_ptr_q <= 3'd0;
            wr_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                table_q[i] <= 16'h0000;
            end
        end else begin
            state_q  <= state_d;
            new_pc_q <= new_pc_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 3'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 3'd1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 4'd1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 4'd1;
            end
            // Lookups above read table_q before this write lands: old value wins.
            if (bus.tbl_wen) begin
                table_q[bus.tbl_waddr] <= bus.tbl_wdata;
            end
        end
    end

    // Storage needs no reset; pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            fifo_q[wr_ptr_q] <= bus.queue_number;
        end
    end

`ifdef DISPATCH_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    assign bus.new_pc     = new_pc_q;
    assign bus.idle       = state_q;
    assign bus.fifo_count = count_q;
    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;
endmodule

// File: tb/tb_work_dispatcher.sv
// Directed bench for work_dispatcher: driver tasks push expected entry PCs into exp_q,
// a negedge monitor pops and compares whenever the DUT performs a dispatch.
module tb_work_dispatcher;
    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    logic evt_q;
    logic [15:0] exp_q [$];

    work_dispatcher_if bus ();

    work_dispatcher dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tbl(input logic [3:0] idx, input logic [15:0] data);
        bus.tbl_wen   = 1'b1;
        bus.tbl_waddr = idx;
        bus.tbl_wdata = data;
        tick();
        bus.tbl_wen   = 1'b0;
    endtask

    task automatic push(input logic [3:0] id);
        bus.queue_wen    = 1'b1;
        bus.queue_number = id;
        tick();
        bus.queue_wen    = 1'b0;
    endtask

    task automatic request();
        bus.request_new_pc = 1'b1;
        tick();
        bus.request_new_pc = 1'b0;
    endtask

    // A dispatch happens at the edge after a cycle where the FIFO is non-empty and
    // either a request arrives in SERVE or the core is waiting.
    always @(negedge clk) begin
        if (evt_q) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_dispatch: got new_pc 0x%0h, expected no dispatch", bus.new_pc);
            end else begin
                check("dispatch_new_pc", bus.new_pc, exp_q.pop_front());
                check("dispatch_idle", {14'd0, bus.idle}, 16'd0);
            end
        end
        evt_q = rst_n && !bus.fifo_empty &&
                ((bus.request_new_pc && bus.idle == 2'b00) || bus.idle == 2'b01);
    end

    initial begin
        tests  = 0;
        failed = 0;
        evt_q  = 1'b0;
        rst_n  = 1'b0;
        bus.queue_wen      = 1'b0;
        bus.queue_number   = 4'd0;
        bus.request_new_pc = 1'b0;
        bus.halt           = 1'b0;
        bus.tbl_wen        = 1'b0;
        bus.tbl_waddr      = 4'd0;
        bus.tbl_wdata      = 16'd0;

        tick();
        tick();
        check("rst_idle", {14'd0, bus.idle}, 16'd1);
        check("rst_new_pc", bus.new_pc, 16'h0000);
        check("rst_count", {12'd0, bus.fifo_count}, 16'd0);
        check("rst_empty", {15'd0, bus.fifo_empty}, 16'd1);
        check("rst_full", {15'd0, bus.fifo_full}, 16'd0);
        rst_n = 1'b1;
        tick();

        // First push launches the core out of the post-reset wait.
        write_tbl(4'd3, 16'h0040);
        exp_q.push_back(16'h0040);
        push(4'd3);
        check("launch_count_push", {12'd0, bus.fifo_count}, 16'd1);
        check("launch_idle_push", {14'd0, bus.idle}, 16'd1);
        tick();
        check("launch_new_pc", bus.new_pc, 16'h0040);
        check("launch_idle", {14'd0, bus.idle}, 16'd0);
        check("launch_count", {12'd0, bus.fifo_count}, 16'd0);

        // Two requests in SERVE drain two queued ids in order.
        write_tbl(4'd1, 16'h1111);
        write_tbl(4'd2, 16'h2222);
        push(4'd1);
        push(4'd2);
        check("serve_count2", {12'd0, bus.fifo_count}, 16'd2);
        exp_q.push_back(16'h1111);
        request();
        check("serve_pc1", bus.new_pc, 16'h1111);
        check("serve_count1", {12'd0, bus.fifo_count}, 16'd1);
        exp_q.push_back(16'h2222);
        request();
        check("serve_pc2", bus.new_pc, 16'h2222);
        check("serve_empty", {15'd0, bus.fifo_empty}, 16'd1);

        // Fill to 8, ninth push (id 12) must be dropped.
        for (int i = 4; i <= 12; i++) write_tbl(i[3:0], 16'h0100 + 16'(i));
        write_tbl(4'd13, 16'h0D0D);
        for (int i = 4; i <= 12; i++) push(i[3:0]);
        check("full_count", {12'd0, bus.fifo_count}, 16'd8);
        check("full_flag", {15'd0, bus.fifo_full}, 16'd1);
`ifdef DISPATCH_DROP_CNT_EN
        check("drop_cnt_one", {8'd0, bus.drop_cnt}, 16'd1);
`endif

        // Full FIFO: push and pop in the same cycle both take effect.
        exp_q.push_back(16'h0104);
        bus.queue_wen      = 1'b1;
        bus.queue_number   = 4'd13;
        bus.request_new_pc = 1'b1;
        tick();
        bus.queue_wen      = 1'b0;
        bus.request_new_pc = 1'b0;
        check("fullpp_count", {12'd0, bus.fifo_count}, 16'd8);
        check("fullpp_new_pc", bus.new_pc, 16'h0104);
`ifdef DISPATCH_DROP_CNT_EN
        check("drop_cnt_still_one", {8'd0, bus.drop_cnt}, 16'd1);
`endif
        for (int i = 5; i <= 11; i++) begin
            exp_q.push_back(16'h0100 + 16'(i));
            request();
        end
        check("drain_count", {12'd0, bus.fifo_count}, 16'd1);

        // Last item is id 13 (id 12 was lost); table write to 13 in the same cycle returns old value.
        exp_q.push_back(16'h0D0D);
        bus.request_new_pc = 1'b1;
        bus.tbl_wen        = 1'b1;
        bus.tbl_waddr      = 4'd13;
        bus.tbl_wdata      = 16'hBEEF;
        tick();
        bus.request_new_pc = 1'b0;
        bus.tbl_wen        = 1'b0;
        check("rdw_old_value", bus.new_pc, 16'h0D0D);
        check("drain_empty", {15'd0, bus.fifo_empty}, 16'd1);

        // Request on empty with halt parks the core; release returns to WAIT.
        bus.halt           = 1'b1;
        bus.request_new_pc = 1'b1;
        tick();
        bus.request_new_pc = 1'b0;
        check("halt_idle", {14'd0, bus.idle}, 16'd2);
        tick();
        check("halt_hold_idle", {14'd0, bus.idle}, 16'd2);
        check("halt_hold_pc", bus.new_pc, 16'h0D0D);
        bus.halt = 1'b0;
        tick();
        check("unhalt_idle", {14'd0, bus.idle}, 16'd1);
        request();
        check("wait_req_ignored", {14'd0, bus.idle}, 16'd1);
        exp_q.push_back(16'h0105);
        push(4'd5);
        tick();
        check("wake_idle", {14'd0, bus.idle}, 16'd0);
        check("wake_new_pc", bus.new_pc, 16'h0105);
        check("wake_empty", {15'd0, bus.fifo_empty}, 16'd1);

        // Non-full simultaneous push/pop keeps the count; id 13 now reads the new table value.
        push(4'd1);
        exp_q.push_back(16'h1111);
        bus.queue_wen      = 1'b1;
        bus.queue_number   = 4'd13;
        bus.request_new_pc = 1'b1;
        tick();
        bus.queue_wen      = 1'b0;
        bus.request_new_pc = 1'b0;
        check("pp_count", {12'd0, bus.fifo_count}, 16'd1);
        check("pp_new_pc", bus.new_pc, 16'h1111);
        exp_q.push_back(16'hBEEF);
        request();
        check("pp_new_pc2", bus.new_pc, 16'hBEEF);

        // Reset mid-operation with items queued.
        push(4'd1);
        push(4'd2);
        push(4'd3);
        push(4'd4);
        check("pre_rst_count", {12'd0, bus.fifo_count}, 16'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_count", {12'd0, bus.fifo_count}, 16'd0);
        check("mid_rst_idle", {14'd0, bus.idle}, 16'd1);
        check("mid_rst_new_pc", bus.new_pc, 16'h0000);
`ifdef DISPATCH_DROP_CNT_EN
        check("mid_rst_drop_cnt", {8'd0, bus.drop_cnt}, 16'd0);
`endif
        // Table entries 3 and 1 held 0x0040 and 0x1111 before reset.
        exp_q.push_back(16'h0000);
        push(4'd3);
        push(4'd1);
        check("zero_tbl3", bus.new_pc, 16'h0000);
        check("zero_tbl_count", {12'd0, bus.fifo_count}, 16'd1);
        exp_q.push_back(16'h0000);
        request();
        check("zero_tbl1", bus.new_pc, 16'h0000);

        tick();
        tick();
        check("exp_q_drained", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/work_dispatcher.md
WORK_DISPATCHER -- requirements
Module: work_dispatcher

Interface
REQ-001 The block SHALL use a single clock and a single reset; reset is synchronous and active-low.
REQ-002 The ports SHALL be as follows:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- queue_wen  in  1  core pushes a work item this cycle.
- queue_number  in  4  work-item (queue) id pushed.
- request_new_pc  in  1  single-cycle pulse; the core asks for its next entry PC.
- new_pc  out  16  entry PC returned to the core.
- idle  out  2  00 = new_pc valid/serving, 01 = waiting for work, 10 = halted, 11 = never driven.
- halt  in  1  level; parks a waiting core.
- tbl_wen  in  1  entry-PC table write strobe.
- tbl_waddr  in  4  table index.
- tbl_wdata  in  16  entry PC for that index.
- fifo_count  out  4  items held, 0..8.
- fifo_full  out  1  fifo_count == 8.
- fifo_empty  out  1  fifo_count == 0.

Function
REQ-003 The block SHALL hold an 8-entry FIFO of 4-bit queue ids with wrapping 3-bit read and write pointers and a 4-bit count.
REQ-004 The block SHALL hold a 16 x 16-bit entry-PC table; tbl_wen writes tbl_wdata to entry tbl_waddr at the clock edge.
REQ-005 A push (queue_wen=1) SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-006 Any other push while full SHALL be dropped, leaving FIFO contents and count unchanged.
REQ-007 State machine: SERVE (idle=00), WAIT (idle=01), HALT (idle=10); idle SHALL be a registered output.
REQ-008 SERVE, request_new_pc=1, FIFO non-empty: the block SHALL pop the head, load new_pc with table[head] at the same edge, and remain in SERVE.
- new_pc and idle=00 are therefore valid one cycle after the request.
REQ-009 SERVE, request_new_pc=1, FIFO empty: the block SHALL go to WAIT (or to HALT if halt=1) with new_pc held.
REQ-010 WAIT with a non-empty FIFO SHALL pop the head, load new_pc with table[head], and return to SERVE.
- halt is ignored in this case.
REQ-011 WAIT with an empty FIFO and halt=1 SHALL go to HALT; HALT with halt=0 SHALL return to WAIT.
- HALT SHALL NOT pop the FIFO.
REQ-012 A push into an empty FIFO SHALL become visible to the pop logic one cycle later; there is no same-cycle bypass.
REQ-013 A simultaneous push and pop SHALL leave the count unchanged and both pointers advanced.
REQ-014 A table write and a lookup of the same index in the same cycle SHALL return the old table value.
REQ-015 request_new_pc asserted in WAIT or HALT SHALL be ignored, because a request is already pending.
REQ-016 fifo_count, fifo_full and fifo_empty SHALL be derived from registered state only.

Reset
REQ-017 With rst_n=0 at a clock edge, the block SHALL clear the FIFO (pointers and count to 0) and zero every table entry.
REQ-018 The same reset SHALL set new_pc=0 and enter WAIT (idle=01) with an implicit pending request, so the first pushed item launches the core.
REQ-019 Reset mid-operation SHALL discard all queued items and any in-flight request; reset has priority over every other input.

Configuration
REQ-020 With DISPATCH_DROP_CNT_EN defined, the block SHALL add output drop_cnt (8 bits, reset 0).
- drop_cnt increments on each dropped push (REQ-006) and saturates at 255.
REQ-021 Without DISPATCH_DROP_CNT_EN, the port and the counter SHALL be absent; all other behaviour is identical.

Verification
REQ-022 Reset, table[3]=0x0040, push id 3 -> cycle after push: pop; next cycle new_pc=0x0040, idle=00, fifo_count=0.
REQ-023 In SERVE, push ids 1,2; request pulse -> next cycle new_pc=table[1], fifo_count=1; second request -> new_pc=table[2], fifo_empty=1.
REQ-024 9 pushes with no requests -> fifo_full=1, fifo_count=8, 9th item lost; drop_cnt=1 when the macro is defined.
REQ-025 Full FIFO, push and request in the same cycle -> push accepted, fifo_count stays 8, new_pc=table[old head].
REQ-026 Request with empty FIFO and halt=1 -> idle=10; halt=0 -> idle=01; push id 5 -> idle=00, new_pc=table[5].
REQ-027 Reset asserted with 4 items queued and in SERVE -> next cycle fifo_count=0, idle=01, new_pc=0, table zeroed.
